// File: rtl/sram_responder.sv
// Target side of the single-cycle sram-like bus: word array with byte-lane writes,
// 1-cycle registered reads, post-reset zero sweep, range-error capture and access counters.
module sram_responder #(
   parameter int unsigned ADDR_WIDTH = 16,
   parameter logic [31:0] BASE_ADDR  = 32'h0,
   parameter bit          INIT_ZERO  = 1'b1
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        sram_en,
   input  logic [3:0]  sram_wen,
   input  logic [31:0] sram_addr,
   input  logic [31:0] sram_wdata,
   output logic [31:0] sram_rdata,
   output logic        init_done,
   output logic        addr_err,
   output logic [31:0] err_addr,
   output logic [31:0] rd_count,
   output logic [31:0] wr_count
);

   localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

   typedef enum logic {ST_INIT, ST_READY} state_t;
   localparam state_t RESET_STATE = INIT_ZERO ? ST_INIT : ST_READY;

   state_t                state_reg, state_next;
   logic [ADDR_WIDTH-1:0] idx_reg, idx_next;
   logic [31:0]           mem [DEPTH];

   logic [31:0]           rdata_reg;
   logic                  addr_err_reg;
   logic [31:0]           err_addr_reg;
   logic [31:0]           rd_count_reg;
   logic [31:0]           wr_count_reg;

   logic [31:0]           offset;
   logic                  in_range;
   logic [ADDR_WIDTH-1:0] word;
   logic                  accepted;
   logic                  sweeping;
   logic [ADDR_WIDTH-1:0] wr_word;
   logic [31:0]           wr_data;
   logic [3:0]            lane_we;
   logic                  unused_bits;

   // Bus address is physical; subtract the window base with 32-bit wrap so addresses
   // below BASE_ADDR land far out of range.
   assign offset      = sram_addr - BASE_ADDR;
   assign in_range    = (offset[31:ADDR_WIDTH+2] == '0);
   assign word        = offset[ADDR_WIDTH+1:2];
   assign unused_bits = ^offset[1:0];

   assign init_done = (state_reg == ST_READY);
   assign accepted  = sram_en & init_done;
   assign sweeping  = (state_reg == ST_INIT);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_reg <= RESET_STATE;
         idx_reg   <= '0;
      end else begin
         state_reg <= state_next;
         idx_reg   <= idx_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      idx_next   = idx_reg;
      case (state_reg)
         ST_INIT: begin
            idx_next = idx_reg + 1'b1;
            if (idx_reg == '1) state_next = ST_READY;
         end
         default: begin
            state_next = ST_READY;
         end
      endcase
   end

   // One write port shared by the sweep and the bus; the sweep owns it while in INIT.
   assign wr_word = sweeping ? idx_reg : word;
   assign wr_data = sweeping ? 32'h0 : sram_wdata;

   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_lane
         assign lane_we[gi] = resetn & (sweeping | (accepted & in_range & sram_wen[gi]));
      end
   endgenerate

   always_ff @(posedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (lane_we[i]) mem[wr_word][8*i +: 8] <= wr_data[8*i +: 8];
      end
   end

   // Read-first: a write cycle returns the word as it was before the lane update.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         rdata_reg <= '0;
      end else if (accepted) begin
         rdata_reg <= in_range ? mem[word] : 32'h0;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         addr_err_reg <= 1'b0;
         err_addr_reg <= '0;
         rd_count_reg <= '0;
         wr_count_reg <= '0;
      end else if (accepted) begin
         if (sram_wen == 4'h0) rd_count_reg <= rd_count_reg + 32'd1;
         else                  wr_count_reg <= wr_count_reg + 32'd1;
         if (!in_range) begin
            addr_err_reg <= 1'b1;
            if (!addr_err_reg) err_addr_reg <= sram_addr;
         end
      end
   end

   assign sram_rdata = rdata_reg;
   assign addr_err   = addr_err_reg;
   assign err_addr   = err_addr_reg;
   assign rd_count   = rd_count_reg;
   assign wr_count   = wr_count_reg;

endmodule

// File: tb/tb_sram_responder.sv
// Randomized scoreboard bench for sram_responder (ADDR_WIDTH=4, BASE=A000_0000).
module tb_sram_responder;

   localparam int          AW    = 4;
   localparam int          DEPTH = 16;
   localparam logic [31:0] BASE  = 32'hA000_0000;

   logic        clk = 1'b0;
   logic        resetn = 1'b1;
   logic        sram_en = 1'b0;
   logic [3:0]  sram_wen = 4'h0;
   logic [31:0] sram_addr = 32'h0;
   logic [31:0] sram_wdata = 32'h0;
   logic [31:0] sram_rdata, err_addr, rd_count, wr_count;
   logic        init_done, addr_err;
   logic [31:0] r0_rdata, r0_err_addr, r0_rd_count, r0_wr_count;
   logic        r0_init_done, r0_addr_err;

   always #5 clk = ~clk;

   sram_responder #(.ADDR_WIDTH(AW), .BASE_ADDR(BASE), .INIT_ZERO(1'b1)) dut (
      .clk(clk), .resetn(resetn), .sram_en(sram_en), .sram_wen(sram_wen),
      .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
      .init_done(init_done), .addr_err(addr_err), .err_addr(err_addr),
      .rd_count(rd_count), .wr_count(wr_count));

   sram_responder #(.ADDR_WIDTH(AW), .BASE_ADDR(BASE), .INIT_ZERO(1'b0)) dut0 (
      .clk(clk), .resetn(resetn), .sram_en(sram_en), .sram_wen(sram_wen),
      .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_rdata(r0_rdata),
      .init_done(r0_init_done), .addr_err(r0_addr_err), .err_addr(r0_err_addr),
      .rd_count(r0_rd_count), .wr_count(r0_wr_count));

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model state
   logic [31:0] exp_q[$];
   logic [31:0] mem_m[DEPTH];
   logic [31:0] rdc, wrc, erra, last_rd, mon_exp;
   logic        err;
   int          left;
   logic        pending = 1'b0;
   logic        mon_on = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: every accepted access yields exactly one rdata one cycle later.
   always begin
      @(posedge clk);
      if (pending) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL rdata: response with empty scoreboard");
         end else begin
            mon_exp = exp_q.pop_front();
            #1;
            chk("rdata", sram_rdata, mon_exp);
            last_rd = mon_exp;
         end
      end else if (mon_on) begin
         #1;
         chk("rdata_hold", sram_rdata, last_rd);
      end
   end

   task automatic access(input bit en, input logic [3:0] wen, input logic [31:0] addr,
                         input logic [31:0] wd);
      logic [31:0] off;
      logic [31:0] old;
      bit          acc;
      @(negedge clk);
      chk("init_done", 32'(init_done), 32'(left == 0));
      chk("rd_count", rd_count, rdc);
      chk("wr_count", wr_count, wrc);
      chk("addr_err", 32'(addr_err), 32'(err));
      chk("err_addr", err_addr, erra);
      sram_en    = en;
      sram_wen   = wen;
      sram_addr  = addr;
      sram_wdata = wd;
      acc = en && (left == 0);
      if (left > 0) left--;
      pending = acc;
      if (acc) begin
         off = addr - BASE;
         if (wen == 4'h0) rdc++;
         else             wrc++;
         if (off < 32'(4 * DEPTH)) begin
            old = mem_m[off[5:2]];
            for (int b = 0; b < 4; b++)
               if (wen[b]) mem_m[off[5:2]][8*b +: 8] = wd[8*b +: 8];
            exp_q.push_back(old);
         end else begin
            exp_q.push_back(32'h0);
            if (!err) begin
               err  = 1'b1;
               erra = addr;
            end
         end
      end
   endtask

   // Pulse resetn low for one cycle; optionally check that the INIT_ZERO=0 copy
   // is ready at once and still holds k0 at word 5.
   task automatic do_reset(input bit chk0, input logic [31:0] k0);
      @(negedge clk);
      sram_en = 1'b0;
      pending = 1'b0;
      resetn  = 1'b0;
      last_rd = 32'h0;
      mon_on  = 1'b1;
      #1;
      chk("rst_rdata", sram_rdata, 32'h0);
      chk("rst_init_done", 32'(init_done), 32'h0);
      chk("rst_rd_count", rd_count, 32'h0);
      chk("rst_wr_count", wr_count, 32'h0);
      chk("rst_addr_err", 32'(addr_err), 32'h0);
      chk("rst_err_addr", err_addr, 32'h0);
      chk("r0_init_done", 32'(r0_init_done), 32'h1);
      @(negedge clk);
      resetn    = 1'b1;
      sram_en   = 1'b1;
      sram_wen  = 4'h0;
      sram_addr = BASE + 32'd20;
      left = DEPTH - 1;
      rdc  = 32'h0;
      wrc  = 32'h0;
      err  = 1'b0;
      erra = 32'h0;
      foreach (mem_m[i]) mem_m[i] = 32'h0;
      exp_q.delete();
      if (chk0) begin
         @(posedge clk);
         #1;
         chk("r0_retained", r0_rdata, k0);
      end
   endtask

   task automatic sweep_and_scan();
      while (left > 0)
         access(1'b1, 4'hF, BASE + 32'(4 * $urandom_range(0, 15)), $urandom);
      for (int i = 0; i < DEPTH; i++)
         access(1'b1, 4'h0, BASE + 32'(4 * i), 32'h0);
   endtask

   logic [31:0] addr_r;
   int          sel;

   initial begin
      do_reset(1'b0, 32'h0);
      sweep_and_scan();

      // Byte lanes
      access(1'b1, 4'hF, BASE + 32'h8, 32'h1122_3344);
      access(1'b1, 4'b0101, BASE + 32'h8, 32'hAABB_CCDD);
      access(1'b1, 4'h0, BASE + 32'hA, 32'h0);
      access(1'b0, 4'h0, BASE, 32'h0);

      // Read-first then back-to-back read of the same word
      access(1'b1, 4'hF, BASE + 32'hC, 32'd5);
      access(1'b1, 4'hF, BASE + 32'hC, 32'd9);
      access(1'b1, 4'h0, BASE + 32'hC, 32'h0);

      // Range errors: first error address is kept
      access(1'b1, 4'hF, BASE, 32'h0BAD_F00D);
      access(1'b1, 4'h0, BASE + 32'h40, 32'h0);
      access(1'b1, 4'hF, BASE + 32'h80, 32'hDEAD_BEEF);
      access(1'b1, 4'h0, BASE, 32'h0);
      access(1'b1, 4'h0, 32'h9FFF_FFFC, 32'h0);
      access(1'b1, 4'h0, BASE, 32'h0);

      // Reset mid-traffic; word 5 should survive in the INIT_ZERO=0 copy
      access(1'b1, 4'hF, BASE + 32'd20, 32'h5A5A_1234);
      access(1'b1, 4'h0, BASE + 32'd20, 32'h0);
      do_reset(1'b1, 32'h5A5A_1234);
      sweep_and_scan();

      // Randomized traffic
      for (int n = 0; n < 300; n++) begin
         sel = $urandom_range(0, 19);
         if (sel == 0)      addr_r = BASE + 32'h40 + 32'($urandom_range(0, 255));
         else if (sel == 1) addr_r = BASE - 32'(4 * (1 + $urandom_range(0, 3)));
         else               addr_r = BASE + 32'($urandom_range(0, 63));
         access($urandom_range(0, 3) != 0,
                ($urandom_range(0, 1) != 0) ? 4'($urandom) : 4'h0,
                addr_r, $urandom);
      end

      // Write counter wrap
      @(negedge clk);
      sram_en = 1'b0;
      pending = 1'b0;
      force dut.wr_count_reg = 32'hFFFF_FFFF;
      #1;
      release dut.wr_count_reg;
      wrc = 32'hFFFF_FFFF;
      access(1'b1, 4'hF, BASE + 32'h4, 32'h7777_7777);
      access(1'b1, 4'h0, BASE + 32'h4, 32'h0);
      access(1'b0, 4'h0, BASE, 32'h0);
      access(1'b0, 4'h0, BASE, 32'h0);

      chk("scoreboard_empty", 32'(exp_q.size()), 32'h0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
